// File: rtl/m2vblkseq.sv
// m2vblkseq -- per-macroblock block sequencer for the inverse-scan/dequantizer.
//
// Accepts one macroblock command, then walks its NUM_BLOCKS blocks in order.
// For every block it issues the ISDQ block_start (and, for coded blocks,
// block_end) handshake, holds the block sideband stable for the whole block,
// and tells the coefficient VLD when to decode. Watchdog and overrun errors are
// sticky until reset or softreset.
//
// Ports:
//   clk, reset_n (async, active low), softreset (sync clear)
//   mb_start/mb_cbp/mb_intra/mb_skip : macroblock command
//   mb_busy, mb_done                 : macroblock status
//   ready_isdq, block_start, block_end, blk_enable, blk_coded, blk_index : ISDQ side
//   vld_start, vld_eob               : coefficient VLD side
//   err_timeout, err_overrun         : sticky error flags
module m2vblkseq #(
  parameter int NUM_BLOCKS = 6,
  parameter int TIMEOUT    = 4095
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       softreset,
  input  logic       mb_start,
  input  logic [7:0] mb_cbp,
  input  logic       mb_intra,
  input  logic       mb_skip,
  output logic       mb_busy,
  output logic       mb_done,
  input  logic       ready_isdq,
  output logic       block_start,
  output logic       block_end,
  output logic       blk_enable,
  output logic       blk_coded,
  output logic [2:0] blk_index,
  output logic       vld_start,
  input  logic       vld_eob,
  output logic       err_timeout,
  output logic       err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_START, S_HOLD, S_DECODE, S_END, S_NEXT
  } state_t;

  localparam logic [2:0]  LAST_IDX  = 3'(NUM_BLOCKS - 1);
  // The counter starts at 0 in the first cycle of a state, so matching
  // TIMEOUT-1 means the limit is reached on this edge.
  localparam logic [11:0] WDOG_LAST = 12'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cbp;
  logic        r_en;
  logic [2:0]  r_index;
  logic [11:0] r_wdog;
  logic        r_mb_busy, r_mb_done, r_block_start, r_block_end;
  logic        r_blk_enable, r_blk_coded, r_vld_start;
  logic        r_err_timeout, r_err_overrun;

  logic       w_last;
  logic [2:0] w_index_next;
  logic       w_coded_cur;
  logic       w_coded_next;
  logic       w_wdog_hit;

  // Block i owns pattern bit (NUM_BLOCKS-1-i); bits above the block count are
  // never selected.
  assign w_last       = (r_index == LAST_IDX);
  assign w_index_next = r_index + 3'd1;
  assign w_coded_cur  = r_cbp[LAST_IDX - r_index] & r_en;
  assign w_coded_next = r_cbp[LAST_IDX - w_index_next] & r_en;
  assign w_wdog_hit   = (r_wdog == WDOG_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cbp         <= '0;
      r_en          <= 1'b0;
      r_index       <= '0;
      r_wdog        <= '0;
      r_mb_busy     <= 1'b0;
      r_mb_done     <= 1'b0;
      r_block_start <= 1'b0;
      r_block_end   <= 1'b0;
      r_blk_enable  <= 1'b0;
      r_blk_coded   <= 1'b0;
      r_vld_start   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else if (softreset) begin
      r_state       <= S_IDLE;
      r_cbp         <= '0;
      r_en          <= 1'b0;
      r_index       <= '0;
      r_wdog        <= '0;
      r_mb_busy     <= 1'b0;
      r_mb_done     <= 1'b0;
      r_block_start <= 1'b0;
      r_block_end   <= 1'b0;
      r_blk_enable  <= 1'b0;
      r_blk_coded   <= 1'b0;
      r_vld_start   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      // Single-cycle pulses and the watchdog default to idle; the watchdog
      // only counts in the branches that stay in WAIT_RDY or DECODE.
      r_mb_done     <= 1'b0;
      r_block_start <= 1'b0;
      r_block_end   <= 1'b0;
      r_vld_start   <= 1'b0;
      r_wdog        <= '0;

      if (mb_start && (r_state != S_IDLE))
        r_err_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (mb_start) begin
            r_cbp     <= mb_skip ? 8'h00 : (mb_intra ? 8'hFF : mb_cbp);
            r_en      <= ~mb_skip;
            r_index   <= '0;
            r_mb_busy <= 1'b1;
            r_state   <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (ready_isdq) begin
            r_block_start <= 1'b1;
            r_blk_enable  <= r_en;
            r_blk_coded   <= w_coded_cur;
            r_state       <= S_START;
          end else if (w_wdog_hit) begin
            // Flag and keep waiting; a block never starts without ready.
            r_err_timeout <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 12'd1;
          end
        end
        S_START: begin
          r_vld_start <= r_blk_coded;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          // ready_isdq is stale here; uncoded blocks close inside ISDQ.
          if (r_blk_coded) begin
            r_state <= S_DECODE;
          end else begin
            r_mb_done <= w_last;
            if (w_last) r_mb_busy <= 1'b0;
            r_state <= S_NEXT;
          end
        end
        S_DECODE: begin
          if (vld_eob) begin
            r_block_end <= 1'b1;
            r_state     <= S_END;
          end else if (w_wdog_hit) begin
            r_err_timeout <= 1'b1;
            r_block_end   <= 1'b1;
            r_state       <= S_END;
          end else begin
            r_wdog <= r_wdog + 12'd1;
          end
        end
        S_END: begin
          r_mb_done <= w_last;
          if (w_last) r_mb_busy <= 1'b0;
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            r_index <= w_index_next;
            // The ready check of WAIT_RDY is folded in here so uncoded
            // blocks can start every third cycle.
            if (ready_isdq) begin
              r_block_start <= 1'b1;
              r_blk_enable  <= r_en;
              r_blk_coded   <= w_coded_next;
              r_state       <= S_START;
            end else begin
              r_state <= S_WAIT_RDY;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mb_busy     = r_mb_busy;
  assign mb_done     = r_mb_done;
  assign block_start = r_block_start;
  assign block_end   = r_block_end;
  assign blk_enable  = r_blk_enable;
  assign blk_coded   = r_blk_coded;
  assign blk_index   = r_index;
  assign vld_start   = r_vld_start;
  assign err_timeout = r_err_timeout;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_m2vblkseq.sv
// Directed bench for m2vblkseq. Instance a uses the default watchdog, instance
// b uses TIMEOUT=15; both share stimulus and sel_b picks the observed one.
module tb_m2vblkseq;

  logic       clk = 1'b0;
  logic       reset_n, softreset, mb_start, mb_intra, mb_skip, ready_isdq;
  logic       vld_eob = 1'b0;
  logic [7:0] mb_cbp;

  logic       busy_a, done_a, bs_a, be_a, en_a, cod_a, vs_a, to_a, ov_a;
  logic       busy_b, done_b, bs_b, be_b, en_b, cod_b, vs_b, to_b, ov_b;
  logic [2:0] idx_a, idx_b;

  m2vblkseq u_dut_a (
    .clk(clk), .reset_n(reset_n), .softreset(softreset), .mb_start(mb_start),
    .mb_cbp(mb_cbp), .mb_intra(mb_intra), .mb_skip(mb_skip), .mb_busy(busy_a),
    .mb_done(done_a), .ready_isdq(ready_isdq), .block_start(bs_a), .block_end(be_a),
    .blk_enable(en_a), .blk_coded(cod_a), .blk_index(idx_a), .vld_start(vs_a),
    .vld_eob(vld_eob), .err_timeout(to_a), .err_overrun(ov_a)
  );

  m2vblkseq #(.NUM_BLOCKS(6), .TIMEOUT(15)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .softreset(softreset), .mb_start(mb_start),
    .mb_cbp(mb_cbp), .mb_intra(mb_intra), .mb_skip(mb_skip), .mb_busy(busy_b),
    .mb_done(done_b), .ready_isdq(ready_isdq), .block_start(bs_b), .block_end(be_b),
    .blk_enable(en_b), .blk_coded(cod_b), .blk_index(idx_b), .vld_start(vs_b),
    .vld_eob(vld_eob), .err_timeout(to_b), .err_overrun(ov_b)
  );

  always #5 clk = ~clk;

  logic        sel_b = 1'b0;
  logic [11:0] obs_a, obs_b, obs;
  assign obs_a = {busy_a, done_a, bs_a, be_a, en_a, cod_a, idx_a, vs_a, to_a, ov_a};
  assign obs_b = {busy_b, done_b, bs_b, be_b, en_b, cod_b, idx_b, vs_b, to_b, ov_b};
  assign obs   = sel_b ? obs_b : obs_a;

  logic       o_busy, o_done, o_bs, o_be, o_en, o_cod, o_vs, o_to, o_ov;
  logic [2:0] o_idx;
  assign {o_busy, o_done, o_bs, o_be, o_en, o_cod, o_idx, o_vs, o_to, o_ov} = obs;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor on the selected instance.
  int         clr_req = 0, clr_ack = 0;
  int         n_bs = 0, n_vs = 0, n_be = 0, n_done = 0;
  logic [7:0] coded_seq = '0, en_seq = '0, vs_mask = '0, be_mask = '0;
  int         bs_cyc[8], vs_cyc[8], be_cyc[8];
  int         done_cyc = 0, to_cyc = 0;
  logic       to_seen = 1'b0;

  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      clr_ack   <= clr_req;
      n_bs      <= 0;
      n_vs      <= 0;
      n_be      <= 0;
      n_done    <= 0;
      coded_seq <= '0;
      en_seq    <= '0;
      vs_mask   <= '0;
      be_mask   <= '0;
      to_seen   <= 1'b0;
    end else begin
      if (o_bs) begin
        if (n_bs < 8) bs_cyc[n_bs] <= cyc;
        n_bs      <= n_bs + 1;
        coded_seq <= {coded_seq[6:0], o_cod};
        en_seq    <= {en_seq[6:0], o_en};
      end
      if (o_vs) begin
        n_vs           <= n_vs + 1;
        vs_mask[o_idx] <= 1'b1;
        vs_cyc[o_idx]  <= cyc;
      end
      if (o_be) begin
        n_be           <= n_be + 1;
        be_mask[o_idx] <= 1'b1;
        be_cyc[o_idx]  <= cyc;
      end
      if (o_done) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
      end
      if (o_to && !to_seen) begin
        to_seen <= 1'b1;
        to_cyc  <= cyc;
      end
    end
  end

  // VLD model: vld_eob in the 4th DECODE cycle, withheld for one chosen block.
  int   eob_cnt = 0;
  logic eob_hold = 1'b0;
  int   withhold_idx = -1;
  always @(negedge clk) begin
    vld_eob <= 1'b0;
    if (o_vs) begin
      eob_cnt  <= 4;
      eob_hold <= (int'(o_idx) == withhold_idx);
    end else if (eob_cnt != 0) begin
      eob_cnt <= eob_cnt - 1;
      if (eob_cnt == 1 && !eob_hold) vld_eob <= 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    clr_req++;
    @(negedge clk);
    tick(1);
  endtask

  task automatic sreset();
    softreset = 1'b1;
    tick(1);
    softreset = 1'b0;
  endtask

  int start_cyc = 0;
  task automatic go(input logic [7:0] cbp, input logic intra, input logic skip);
    mb_cbp   = cbp;
    mb_intra = intra;
    mb_skip  = skip;
    mb_start = 1'b1;
    tick(1);
    start_cyc = cyc;
    mb_start  = 1'b0;
  endtask

  // kind: 0 = block_start count, 1 = vld_start count, 2 = mb_done count
  task automatic wait_ev(input int kind, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((kind == 0 && n_bs >= n) || (kind == 1 && n_vs >= n) || (kind == 2 && n_done >= n))
        break;
      tick(1);
    end
  endtask

  int rdy_cyc = 0;

  initial begin
    reset_n = 1'b0; softreset = 1'b0; mb_start = 1'b0; mb_cbp = '0;
    mb_intra = 1'b0; mb_skip = 1'b0; ready_isdq = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_val("reset_a", 32'(obs_a), 0);
    check_val("reset_b", 32'(obs_b), 0);
    tick(1);

    // Non-intra cbp 101001 (upper two bits set and must be ignored).
    clr_mon();
    go(8'b1110_1001, 1'b0, 1'b0);
    $display("txn t1: cbp=e9 inter");
    wait_ev(2, 1, 300);
    check_val("t1_nbs", n_bs, 6);
    check_val("t1_coded", 32'(coded_seq), 32'h29);
    check_val("t1_enable", 32'(en_seq), 32'h3f);
    check_val("t1_vs_mask", 32'(vs_mask), 32'h25);
    check_val("t1_be_mask", 32'(be_mask), 32'h25);
    check_val("t1_ndone", n_done, 1);
    check_val("t1_sp_coded", bs_cyc[1] - bs_cyc[0], 8);
    check_val("t1_sp2", bs_cyc[2] - bs_cyc[1], 3);
    check_val("t1_sp4", bs_cyc[4] - bs_cyc[3], 3);
    check_val("t1_sp5", bs_cyc[5] - bs_cyc[4], 3);
    tick(1);
    check_val("t1_busy_after", 32'(o_busy), 0);
    check_val("t1_errs", 32'({o_to, o_ov}), 0);

    // Intra with cbp 0: every block coded.
    clr_mon();
    go(8'h00, 1'b1, 1'b0);
    $display("txn t2: intra cbp=00");
    wait_ev(2, 1, 300);
    check_val("t2_coded", 32'(coded_seq), 32'h3f);
    check_val("t2_nvs", n_vs, 6);
    check_val("t2_nbe", n_be, 6);

    // Skip wins over intra.
    clr_mon();
    go(8'hff, 1'b1, 1'b1);
    $display("txn t3: skip+intra");
    wait_ev(2, 1, 300);
    check_val("t3_enable", 32'(en_seq), 0);
    check_val("t3_coded", 32'(coded_seq), 0);
    check_val("t3_nvs", n_vs, 0);
    check_val("t3_nbs", n_bs, 6);
    check_val("t3_done_lat", done_cyc - start_cyc, 18);

    // ready_isdq low for 20 cycles before block 3.
    clr_mon();
    go(8'h00, 1'b0, 1'b0);
    wait_ev(0, 3, 100);
    ready_isdq = 1'b0;
    tick(20);
    ready_isdq = 1'b1;
    rdy_cyc = cyc;
    $display("txn t4: ready released at cycle %0d", rdy_cyc);
    wait_ev(2, 1, 300);
    check_val("t4_bs3_cycle", bs_cyc[3], rdy_cyc + 1);
    check_val("t4_nbs", n_bs, 6);
    check_val("t4_no_timeout", 32'(o_to), 0);

    // Watchdog on instance b: eob withheld on block 1.
    sreset();
    sel_b = 1'b1;
    withhold_idx = 1;
    clr_mon();
    go(8'h3f, 1'b0, 1'b0);
    $display("txn t5: watchdog, block 1 eob withheld");
    wait_ev(2, 1, 400);
    check_val("t5_to_delay", to_cyc - vs_cyc[1], 16);
    check_val("t5_forced_end", be_cyc[1], to_cyc);
    check_val("t5_vs_mask", 32'(vs_mask), 32'h3f);
    check_val("t5_nbe", n_be, 6);
    check_val("t5_ndone", n_done, 1);
    tick(5);
    check_val("t5_sticky", 32'(o_to), 1);
    sreset();
    @(negedge clk);
    check_val("t5_cleared", 32'(o_to), 0);
    withhold_idx = -1;
    sel_b = 1'b0;
    tick(1);

    // Overrun during block 2.
    sreset();
    clr_mon();
    go(8'b0010_1001, 1'b0, 1'b0);
    wait_ev(0, 3, 100);
    mb_cbp = 8'hff; mb_intra = 1'b1; mb_start = 1'b1;
    tick(1);
    mb_start = 1'b0; mb_intra = 1'b0;
    $display("txn t6: overrun during block 2");
    wait_ev(2, 1, 300);
    check_val("t6_overrun", 32'(o_ov), 1);
    check_val("t6_coded", 32'(coded_seq), 32'h29);
    check_val("t6_nbs", n_bs, 6);
    check_val("t6_ndone", n_done, 1);

    // softreset inside DECODE.
    sreset();
    check_val("t7_ov_cleared", 32'(o_ov), 0);
    clr_mon();
    go(8'h00, 1'b1, 1'b0);
    wait_ev(1, 1, 100);
    tick(1);
    $display("txn t7: softreset in DECODE");
    sreset();
    @(negedge clk);
    check_val("t7_busy", 32'(o_busy), 0);
    clr_mon();
    tick(40);
    check_val("t7_nbe", n_be, 0);
    check_val("t7_ndone", n_done, 0);
    check_val("t7_nbs", n_bs, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
